// File: rtl/my_rom_loader.sv
// Program ROM with a streamed boot loader: header (length), payload, checksum.
// Holds the CPU in reset until a verified image is resident, then serves instructions from pc.
module my_rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_start,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [14:0] pc,
    output logic [15:0] instruction,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_in_ready;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_error;
    logic [15:0]         r_len;
    logic [15:0]         r_sum;
    logic [15:0]         r_words;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_len_ok;
    logic                w_last;
    logic                w_mem_we;

    // load_start wins over a word offered in the same cycle: that word is dropped.
    assign w_accept = in_valid && r_in_ready && !load_start;
    assign w_len_ok = (in_data != 16'd0) && ({1'b0, in_data} <= 17'(DEPTH));
    assign w_last   = (r_words == r_len - 16'd1);
    assign w_mem_we = w_accept && (r_state == S_DATA) && !reset;

    always_comb begin
        w_state_next = r_state;
        if (load_start) begin
            w_state_next = S_HDR;
        end else begin
            case (r_state)
                S_HDR:   if (w_accept) w_state_next = w_len_ok ? S_DATA : S_ERR;
                S_DATA:  if (w_accept && w_last) w_state_next = S_CHK;
                S_CHK:   if (w_accept) w_state_next = (in_data == r_sum) ? S_RUN : S_ERR;
                default: w_state_next = r_state;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they are glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == S_HDR) || (w_state_next == S_DATA) ||
                           (w_state_next == S_CHK);
            r_cpu_reset <= (w_state_next != S_RUN);
            r_done      <= (w_state_next == S_RUN);
            r_error     <= (w_state_next == S_ERR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len   <= '0;
            r_sum   <= '0;
            r_words <= '0;
            r_addr  <= '0;
        end else if (load_start) begin
            r_sum   <= '0;
            r_words <= '0;
            r_addr  <= '0;
        end else if (w_accept) begin
            if (r_state == S_HDR) begin
                r_len <= in_data;
            end else if (r_state == S_DATA) begin
                r_sum   <= r_sum + in_data;
                r_words <= r_words + 16'd1;
                r_addr  <= r_addr + 1'b1;
            end
        end
    end

    // ROM contents survive reset; only the loader writes them.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= in_data;
        end
    end

    assign instruction  = r_done ? r_mem[pc[ADDR_W-1:0]] : 16'h0000;
    assign in_ready     = r_in_ready;
    assign cpu_reset    = r_cpu_reset;
    assign done         = r_done;
    assign error        = r_error;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_my_rom_loader.sv
// Randomized bench for my_rom_loader (ADDR_W=4) against an image-level model of ROM contents and load outcome.
module tb_my_rom_loader;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] pc;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;

    logic [15:0] m_mem [DEPTH];
    bit          m_vld [DEPTH];
    logic [15:0] q_pl [$];

    my_rom_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (in_valid && in_ready) n_acc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int gaps);
        int t;
        in_valid = 1'b0;
        repeat (gaps) tick();
        in_valid = 1'b1;
        in_data  = w;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        check("ready_wait", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic fill_rand(input int n);
        q_pl.delete();
        for (int i = 0; i < n; i++) q_pl.push_back(16'($urandom));
    endtask

    task automatic check_outs(input bit run, input bit err, input int wl);
        check("done", done, run);
        check("error", error, err);
        check("cpu_reset", cpu_reset, !run);
        check("in_ready_idle", in_ready, 1'b0);
        check("words_loaded", words_loaded, wl);
        for (int a = 0; a < DEPTH; a++) begin
            if (run && m_vld[a]) begin
                pc = (15'($urandom) & ~15'(DEPTH - 1)) | 15'(a);
                tick();
                check("instr", instruction, m_mem[a]);
            end
        end
        if (!run) begin
            pc = 15'($urandom);
            tick();
            check("instr_zero", instruction, 16'h0000);
        end
    endtask

    // Streams header, payload from q_pl (must hold hdr words when hdr is legal), then checksum ^ cks_xor.
    task automatic do_load(input logic [15:0] hdr, input logic [15:0] cks_xor,
                           input int gap_lo, input int gap_hi);
        logic [15:0] sum;
        bit          ok_hdr;
        bit          run;
        ok_hdr = (hdr != 0) && (hdr <= DEPTH);
        send(hdr, $urandom_range(gap_hi, gap_lo));
        if (!ok_hdr) begin
            $display("load hdr=%0d -> bad length", hdr);
            check_outs(1'b0, 1'b1, 0);
            return;
        end
        sum = 16'h0000;
        for (int i = 0; i < int'(hdr); i++) begin
            send(q_pl[i], $urandom_range(gap_hi, gap_lo));
            sum      = sum + q_pl[i];
            m_mem[i] = q_pl[i];
            m_vld[i] = 1'b1;
        end
        send(sum ^ cks_xor, $urandom_range(gap_hi, gap_lo));
        run = (cks_xor == 16'h0000);
        $display("load hdr=%0d sum=%h sent=%h -> %s", hdr, sum, sum ^ cks_xor, run ? "run" : "bad checksum");
        check_outs(run, !run, int'(hdr));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w0, w1;
        reset      = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        pc         = 15'd0;
        for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1'b0);
        check_outs(1'b0, 1'b0, 0);

        // Nominal image with valid held high throughout.
        pulse_start();
        n_acc = 0;
        q_pl = '{16'h0002, 16'hEC10, 16'h0003};
        do_load(16'd3, 16'h0000, 0, 0);
        check("nom_accepts", n_acc, 5);
        pc = 15'd1; tick(); check("nom_pc1", instruction, 16'hEC10);
        pc = 15'd2; tick(); check("nom_pc2", instruction, 16'h0003);

        // Bad checksum (EC16), then recovery.
        pulse_start();
        do_load(16'd3, 16'hEC15 ^ 16'hEC16, 0, 0);
        pulse_start();
        fill_rand(5);
        do_load(16'd5, 16'h0000, 0, 1);

        // Length bounds.
        pulse_start(); do_load(16'd0, 16'h0000, 0, 0);
        pulse_start(); do_load(16'd17, 16'h0000, 0, 0);
        pulse_start(); fill_rand(16); do_load(16'd16, 16'h0000, 0, 0);

        // Backpressure: valid 1,0,0,1,...
        pulse_start(); fill_rand(6); do_load(16'd6, 16'h0000, 2, 2);

        // load_start from RUN.
        pulse_start();
        check("run_restart_ready", in_ready, 1'b1);
        check("run_restart_cpu_reset", cpu_reset, 1'b1);
        check("run_restart_done", done, 1'b0);
        check("run_restart_wl", words_loaded, 0);

        // Abort: load_start collides with the 2nd payload word.
        fill_rand(4);
        send(16'd4, 0);
        send(q_pl[0], 0);
        m_mem[0] = q_pl[0];
        m_vld[0] = 1'b1;
        in_valid   = 1'b1;
        in_data    = q_pl[1] ^ 16'h5A5A;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        $display("abort during payload word 2");
        check("abort_ready", in_ready, 1'b1);
        check("abort_wl", words_loaded, 0);
        check("abort_cpu_reset", cpu_reset, 1'b1);
        fill_rand(1); do_load(16'd1, 16'h0000, 0, 0);
        pulse_start(); fill_rand(2); do_load(16'd2, 16'h0000, 0, 0);

        // Reset mid-DATA after 2 of 4 words.
        pulse_start();
        w0 = 16'($urandom);
        w1 = 16'($urandom);
        send(16'd4, 0);
        send(w0, 0);
        send(w1, 0);
        m_mem[0] = w0; m_vld[0] = 1'b1;
        m_mem[1] = w1; m_vld[1] = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        $display("reset mid-payload");
        check("rst_mid_ready", in_ready, 1'b0);
        check_outs(1'b0, 1'b0, 0);
        pulse_start(); fill_rand(1); do_load(16'd1, 16'h0000, 0, 0);

        // Randomized images.
        for (int it = 0; it < 30; it++) begin
            int          n;
            logic [15:0] x;
            n = $urandom_range(DEPTH, 1);
            if ($urandom_range(9, 0) == 0) n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(40, DEPTH + 1);
            x = ($urandom_range(4, 0) == 0) ? (16'($urandom) | 16'h0001) : 16'h0000;
            pulse_start();
            fill_rand(n);
            do_load(16'(n), x, 0, 3);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/my_rom_loader.md
Name: my_rom_loader

Overview:
Instruction-memory stage directly upstream of my_cpu: holds the program ROM and drives the CPU's instruction input from its pc output.
Accepts a program image over a 16-bit valid/ready word stream: header (length), payload, checksum.
Holds the CPU in reset until a verified image is resident, then releases it.
Gives the bench and the top level a single boot path instead of $readmemb-only ROM loading.

Parameters:
ADDR_W, 15, ROM address width; DEPTH = 2^ADDR_W words of 16 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
load_start  input  1  single-cycle pulse; begins (or restarts) an image load
in_data  input  16  stream word
in_valid  input  1  in_data valid this cycle
in_ready  output  1  loader will accept in_data this cycle
pc  input  15  CPU program counter (low ADDR_W bits used)
instruction  output  16  instruction word to CPU
cpu_reset  output  1  reset to my_cpu
done  output  1  verified image resident, CPU running
error  output  1  last load failed (bad length or checksum)
words_loaded  output  16  payload words written in current/last load

Behaviour:
- Transfer: a word is accepted on a rising edge when in_valid && in_ready. in_ready is Moore: 1 in HDR, DATA, CHK; 0 otherwise. in_valid may stay high while in_ready=0 with no effect.
- States: IDLE, HDR, DATA, CHK, RUN, ERR. Internal registers: len[15:0], addr[ADDR_W-1:0], sum[15:0].
- Reset values: state=IDLE, in_ready=0, cpu_reset=1, done=0, error=0, words_loaded=0, len/addr/sum=0. ROM contents are NOT cleared by reset.
- IDLE: waits for load_start, then goes to HDR and clears sum, addr, words_loaded and error.
- HDR: on acceptance, len <= in_data.
  - in_data==0 or in_data>DEPTH: go to ERR.
  - Otherwise go to DATA.
- DATA: on each acceptance:
  - mem[addr] <= in_data, sum <= sum + in_data (mod 2^16), addr++, words_loaded++.
  - When the accepted word is number len (words_loaded==len-1 before the increment), go to CHK.
- CHK: on acceptance, in_data==sum goes to RUN; otherwise go to ERR.
- RUN: done=1, cpu_reset=0, in_ready=0. cpu_reset first reads 0 in the cycle after the checksum edge.
- ERR: error=1, done=0, cpu_reset=1. Stays here until load_start or reset.
- load_start in any state, including mid-load or RUN, enters HDR on the next edge.
  - It clears sum, addr, words_loaded, error and done; cpu_reset=1.
  - It takes priority over a same-cycle accepted word, which is discarded (not written, not counted).
- cpu_reset = 1 in every state except RUN. Registered/Moore, so it has no glitches.
- instruction: combinational read of mem[pc[ADDR_W-1:0]] when state==RUN. It is 16'h0000 in all other states.
- Memory write happens on the rising edge.
- reset asserted mid-load: go to IDLE next edge. Partially written words remain in mem. done=0, error=0.
- Words at addresses >= len keep their previous contents; they are not zero-filled.
- Checksum arithmetic: 16-bit wrap-around addition; the carry is discarded.

Test Plan:
- Nominal load: reset, pulse load_start, stream 3, 16'h0002, 16'hEC10, 16'h0003, checksum 16'hEC15, in_valid held high. Required:
  - in_ready=1 for exactly 5 accepting cycles.
  - done=1, cpu_reset=0 on the edge after the checksum; words_loaded=3.
  - pc=1 gives instruction=16'hEC10; pc=2 gives 16'h0003.
- Bad checksum: same stream with checksum 16'hEC16. Required: error=1, done=0, cpu_reset=1, instruction=0.
  - A new load_start followed by a correct stream then reaches RUN with error=0.
- Length bounds: header 0, then ERR. With ADDR_W=4, header 17 gives ERR and header 16 proceeds to DATA.
- Backpressure and stall: in_valid toggles 1,0,0,1,... during DATA. Required: only valid cycles are written/counted, and sum matches.
- load_start while in_ready=0 (in RUN) returns to HDR, cpu_reset=1.
- Abort: load_start pulsed together with the 2nd payload word of a len=4 load. Required:
  - That word is not written.
  - State is HDR, words_loaded=0.
  - A fresh len=2 image then loads and runs.
- Reset mid-DATA: after 2 of 4 words, assert reset for one cycle. Required: IDLE, cpu_reset=1, done=0, error=0, in_ready=0.
  - A subsequent full load succeeds.
  - mem[0..1] still hold the first load's words until overwritten.
